// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared encodings for the vdp99 CPU port
package vdp_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RD_REQ = 2'd1,
        S_WR_REQ = 2'd2
    } vram_state_e;

    // Second control byte din[7:6]; only bit 7 matters for a register write
    localparam logic [1:0] CMD_RD  = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_REG = 2'b10;

    localparam int ST_F  = 7;
    localparam int ST_5S = 6;
    localparam int ST_C  = 5;

endpackage

// File: rtl/vdp_status_reg.sv
// rtl/vdp_status_reg.sv - frame/5th-sprite/collision flags and registered irq
module vdp_status_reg
    import vdp_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       spr5_tick,
    input  logic [4:0] spr5_num,
    input  logic       coll_tick,
    input  logic       clr,
    input  logic       ie,
    output logic [7:0] status,
    output logic       irq
);

    logic       f_q, f_d;
    logic       s5_q, s5_d;
    logic       c_q, c_d;
    logic [4:0] fifth_q, fifth_d;
    logic       irq_q, irq_d;

    always_comb begin
        // A set event in the same cycle as the status-read clear wins
        f_d     = frame_tick | (f_q & ~clr);
        c_d     = coll_tick | (c_q & ~clr);
        s5_d    = spr5_tick | (s5_q & ~clr);
        fifth_d = (spr5_tick && !s5_q) ? spr5_num : fifth_q;
        irq_d   = f_d & ie;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            f_q     <= 1'b0;
            s5_q    <= 1'b0;
            c_q     <= 1'b0;
            fifth_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            f_q     <= f_d;
            s5_q    <= s5_d;
            c_q     <= c_d;
            fifth_q <= fifth_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        status        = '0;
        status[ST_F]  = f_q;
        status[ST_5S] = s5_q;
        status[ST_C]  = c_q;
        status[4:0]   = fifth_q;
    end

    assign irq = irq_q;

endmodule

// File: rtl/vdp_cpu_port.sv
// rtl/vdp_cpu_port.sv - CPU front end: control latch, registers, VRAM address counter, req/ack VRAM access
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int VRAM_AW  = 14,
    parameter int BANK_REG = 14,
    parameter int IE_REG   = 1,
    parameter int IE_BIT   = 5
) (
    input  logic                  pxclk,
    input  logic                  reset_n,
    input  logic                  wr_tick,
    input  logic                  rd_tick,
    input  logic                  mode,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic [NUM_REGS*8-1:0] regs,
    input  logic                  frame_tick,
    input  logic                  spr5_tick,
    input  logic [4:0]            spr5_num,
    input  logic                  coll_tick,
    output logic                  irq,
    output logic                  vram_req,
    output logic                  vram_we,
    output logic [VRAM_AW-1:0]    vram_addr,
    output logic [7:0]            vram_wdata,
    input  logic                  vram_ack,
    input  logic [7:0]            vram_rdata,
    output logic                  overrun
);

    localparam int RIW      = $clog2(NUM_REGS);
    localparam bit BANK_EN  = (VRAM_AW > 14) && (BANK_REG < NUM_REGS);
    localparam int BANK_IDX = BANK_EN ? BANK_REG : 0;

    vram_state_e        state_q, state_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic [VRAM_AW-1:0] req_addr_q, req_addr_d;
    logic [7:0]         req_wdata_q, req_wdata_d;
    logic               flag_q, flag_d;
    logic [7:0]         temp_q, temp_d;
    logic [7:0]         rbuf_q, rbuf_d;
    logic               overrun_q, overrun_d;
    logic [7:0]         regs_q [NUM_REGS];
    logic [7:0]         regs_d [NUM_REGS];

    logic [16:0]        addr_x;
    logic [VRAM_AW-1:0] addr_set;
    logic [RIW-1:0]     reg_idx;
    logic               busy;
    logic               st_clr;
    logic               ie;
    logic [7:0]         status;

    assign addr_x  = 17'(addr_q);
    assign reg_idx = din[RIW-1:0];
    assign busy    = (state_q != S_IDLE);
    assign ie      = regs_q[IE_REG][IE_BIT];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        flag_d      = flag_q;
        temp_d      = temp_q;
        rbuf_d      = rbuf_q;
        overrun_d   = 1'b0;
        regs_d      = regs_q;
        st_clr      = 1'b0;
        // Upper address bits above 13 survive a control-port address set
        addr_set    = VRAM_AW'({addr_x[16:14], din[5:0], temp_q});

        if (vram_ack && state_q == S_RD_REQ) begin
            rbuf_d  = vram_rdata;
            state_d = S_IDLE;
        end else if (vram_ack && state_q == S_WR_REQ) begin
            state_d = S_IDLE;
        end

        if (wr_tick) begin
            if (mode && !flag_q) begin
                temp_d = din;
                flag_d = 1'b1;
            end else begin
                flag_d = 1'b0;
                if (!mode) begin
                    if (busy) begin
                        overrun_d = 1'b1;
                    end else begin
                        rbuf_d      = din;
                        req_addr_d  = addr_q;
                        req_wdata_d = din;
                        state_d     = S_WR_REQ;
                        addr_d      = addr_q + VRAM_AW'(1);
                    end
                end else if (din[7] == CMD_REG[1]) begin
                    regs_d[reg_idx] = temp_q;
                    if (BANK_EN && (int'(reg_idx) == BANK_IDX)) begin
                        addr_d = VRAM_AW'({temp_q[2:0], addr_x[13:0]});
                    end
                end else if (din[7:6] == CMD_WR) begin
                    addr_d = addr_set;
                end else if (din[7:6] == CMD_RD) begin
                    if (busy) begin
                        addr_d    = addr_set;
                        overrun_d = 1'b1;
                    end else begin
                        req_addr_d = addr_set;
                        state_d    = S_RD_REQ;
                        addr_d     = addr_set + VRAM_AW'(1);
                    end
                end
            end
        end else if (rd_tick) begin
            flag_d = 1'b0;
            if (mode) begin
                st_clr = 1'b1;
            end else if (busy) begin
                overrun_d = 1'b1;
            end else begin
                req_addr_d = addr_q;
                state_d    = S_RD_REQ;
                addr_d     = addr_q + VRAM_AW'(1);
            end
        end
    end

    always_ff @(posedge pxclk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            flag_q      <= 1'b0;
            temp_q      <= '0;
            rbuf_q      <= '0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            flag_q      <= flag_d;
            temp_q      <= temp_d;
            rbuf_q      <= rbuf_d;
            overrun_q   <= overrun_d;
            regs_q      <= regs_d;
        end
    end

    vdp_status_reg u_status (
        .clk        (pxclk),
        .resetn     (reset_n),
        .frame_tick (frame_tick),
        .spr5_tick  (spr5_tick),
        .spr5_num   (spr5_num),
        .coll_tick  (coll_tick),
        .clr        (st_clr),
        .ie         (ie),
        .status     (status),
        .irq        (irq)
    );

    for (genvar n = 0; n < NUM_REGS; n++) begin : g_regs
        assign regs[8*n +: 8] = regs_q[n];
    end

    assign dout       = (rd_tick && !wr_tick) ? (mode ? status : rbuf_q) : 8'h00;
    assign vram_req   = (state_q != S_IDLE);
    assign vram_we    = (state_q == S_WR_REQ);
    assign vram_addr  = req_addr_q;
    assign vram_wdata = req_wdata_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// tb/tb_vdp_cpu_port.sv - scoreboard bench for vdp_cpu_port (16 regs, 17-bit VRAM)
module tb_vdp_cpu_port;

    localparam int NR    = 16;
    localparam int AW    = 17;
    localparam int BANK  = 14;
    localparam int IER   = 1;
    localparam int IEB   = 5;
    localparam int AMASK = (1 << AW) - 1;

    logic           pxclk = 1'b0;
    logic           reset_n, wr_tick, rd_tick, mode;
    logic [7:0]     din, dout;
    logic [NR*8-1:0] regs;
    logic           frame_tick, spr5_tick, coll_tick;
    logic [4:0]     spr5_num;
    logic           irq, vram_req, vram_we, vram_ack, overrun;
    logic [AW-1:0]  vram_addr;
    logic [7:0]     vram_wdata, vram_rdata;

    always #5 pxclk = ~pxclk;

    vdp_cpu_port #(.NUM_REGS(NR), .VRAM_AW(AW), .BANK_REG(BANK), .IE_REG(IER), .IE_BIT(IEB)) dut (
        .pxclk(pxclk), .reset_n(reset_n), .wr_tick(wr_tick), .rd_tick(rd_tick), .mode(mode),
        .din(din), .dout(dout), .regs(regs), .frame_tick(frame_tick), .spr5_tick(spr5_tick),
        .spr5_num(spr5_num), .coll_tick(coll_tick), .irq(irq), .vram_req(vram_req),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .vram_ack(vram_ack), .vram_rdata(vram_rdata), .overrun(overrun)
    );

    typedef struct { bit we; int addr; int data; } req_t;
    typedef struct { bit irq; bit ovr; bit req; logic [NR*8-1:0] regs; } st_t;

    req_t req_q[$];
    int   dout_q[$];
    st_t  st_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: architectural state after the most recent edge
    int m_regs[NR];
    int m_addr, m_temp, m_rbuf, m_fifth, m_ack_at;
    bit m_flag, m_f, m_s5, m_c, m_irq, m_pend, m_pwe;
    int cyc = 0;

    int ack_dly = -1;
    int rdata_frc = -1;
    int s_num_frc = 0;
    bit ev_en = 0, stray_ack = 0, f_frc = 0, s_frc = 0;
    bit mon_seen = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_status();
        return (int'(m_f) << 7) | (int'(m_s5) << 6) | (int'(m_c) << 5) | (m_fifth & 31);
    endfunction

    task automatic issue(input bit we, input int addr, input int data);
        m_pend = 1;
        m_pwe = we;
        m_ack_at = cyc + 1 + ((ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly);
        req_q.push_back('{we: we, addr: addr, data: data});
    endtask

    task automatic step(input bit rn, input bit wr, input bit rd, input bit md, input logic [7:0] d);
        bit busy, clr, ie_old, fr, sp, co, ovr;
        int num, idx;
        st_t e;
        fr  = f_frc || (ev_en && $urandom_range(0, 11) == 0);
        sp  = s_frc || (ev_en && $urandom_range(0, 11) == 0);
        co  = ev_en && $urandom_range(0, 11) == 0;
        num = s_frc ? s_num_frc : int'($urandom_range(0, 31));
        reset_n = rn; wr_tick = wr; rd_tick = rd; mode = md; din = d;
        frame_tick = fr; spr5_tick = sp; spr5_num = num[4:0]; coll_tick = co;
        vram_ack   = stray_ack || (m_pend && cyc == m_ack_at);
        vram_rdata = (rdata_frc >= 0) ? 8'(rdata_frc) : 8'($urandom_range(0, 255));
        if (rn && rd && !wr) dout_q.push_back(md ? m_status() : m_rbuf);
        ovr = 0;
        if (!rn) begin
            for (int i = 0; i < NR; i++) m_regs[i] = 0;
            m_addr = 0; m_temp = 0; m_rbuf = 0; m_fifth = 0;
            m_flag = 0; m_f = 0; m_s5 = 0; m_c = 0; m_irq = 0; m_pend = 0;
        end else begin
            busy   = m_pend;
            clr    = rd && !wr && md;
            ie_old = m_regs[IER][IEB];
            if (vram_ack && m_pend) begin
                if (!m_pwe) m_rbuf = vram_rdata;
                m_pend = 0;
            end
            if (wr && md && !m_flag) begin
                m_temp = d;
                m_flag = 1;
            end else if (wr && md) begin
                m_flag = 0;
                if (d[7]) begin
                    idx = int'(d[5:0]) % NR;
                    m_regs[idx] = m_temp;
                    if (idx == BANK) m_addr = (m_addr & 'h3FFF) | ((m_temp % (1 << (AW - 14))) << 14);
                end else begin
                    m_addr = ((m_addr & ~32'h3FFF) | (int'(d[5:0]) << 8) | m_temp) & AMASK;
                    if (!d[6]) begin
                        if (busy) ovr = 1;
                        else begin
                            issue(0, m_addr, 0);
                            m_addr = (m_addr + 1) & AMASK;
                        end
                    end
                end
            end else if (wr) begin
                m_flag = 0;
                if (busy) ovr = 1;
                else begin
                    m_rbuf = d;
                    issue(1, m_addr, d);
                    m_addr = (m_addr + 1) & AMASK;
                end
            end else if (rd) begin
                m_flag = 0;
                if (!md) begin
                    if (busy) ovr = 1;
                    else begin
                        issue(0, m_addr, 0);
                        m_addr = (m_addr + 1) & AMASK;
                    end
                end
            end
            if (sp && !m_s5) m_fifth = num;
            if (clr) begin m_f = 0; m_s5 = 0; m_c = 0; end
            if (fr) m_f = 1;
            if (sp) m_s5 = 1;
            if (co) m_c = 1;
            m_irq = m_f & ie_old;
        end
        e.irq = m_irq; e.ovr = ovr; e.req = m_pend;
        for (int i = 0; i < NR; i++) e.regs[i*8 +: 8] = m_regs[i][7:0];
        @(posedge pxclk);
        #1;
        st_q.push_back(e);
        cyc++;
    endtask

    task automatic idle(); step(1, 0, 0, 0, 8'h00); endtask
    task automatic ctl(input logic [7:0] d); step(1, 1, 0, 1, d); endtask
    task automatic dwr(input logic [7:0] d); step(1, 1, 0, 0, d); endtask
    task automatic drd(); step(1, 0, 1, 0, 8'h00); endtask
    task automatic srd(); step(1, 0, 1, 1, 8'h00); endtask
    task automatic wait_free();
        for (int i = 0; i < 20 && m_pend; i++) idle();
    endtask

    initial begin : monitor
        st_t  e;
        req_t r;
        forever begin
            @(negedge pxclk);
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                check("irq", irq, e.irq);
                check("overrun", overrun, e.ovr);
                check("vram_req", vram_req, e.req);
                check("regs", regs, e.regs);
            end
            if (rd_tick && !wr_tick) begin
                if (dout_q.size() == 0) check("dout_unexpected_read", 1, 0);
                else check("dout", dout, dout_q.pop_front());
            end
            if (rd_tick && wr_tick) check("dout_collide", dout, 0);
            if (vram_req && !mon_seen) begin
                if (req_q.size() == 0) check("req_unexpected", 1, 0);
                else begin
                    r = req_q.pop_front();
                    check("req_we", vram_we, r.we);
                    check("req_addr", vram_addr, r.addr);
                    if (r.we) check("req_wdata", vram_wdata, r.data);
                end
            end
            mon_seen = vram_req && !vram_ack;
        end
    end

    initial begin : driver
        int op;
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        idle();
        check("reset_regs", regs, 0);
        check("reset_irq", irq, 0);
        ack_dly = 3;

        ctl(8'h07); ctl(8'h87);
        check("reg7", regs[63:56], 8'h07);
        check("reg_no_req", vram_req, 0);

        ctl(8'h00); ctl(8'h40);
        dwr(8'hAA);
        check("wr0_addr", vram_addr, 17'h00000);
        check("wr0_data", vram_wdata, 8'hAA);
        check("wr0_we", vram_we, 1);
        wait_free();
        dwr(8'h55);
        check("wr1_addr", vram_addr, 17'h00001);
        check("wr1_data", vram_wdata, 8'h55);
        wait_free();

        ctl(8'h01); ctl(8'h8E);
        ack_dly = 1; rdata_frc = 8'h12;
        ctl(8'hFF); ctl(8'h3F);
        check("ra_addr", vram_addr, 17'h07FFF);
        check("ra_we", vram_we, 0);
        wait_free();
        drd();
        check("rd_carry_addr", vram_addr, 17'h08000);
        wait_free();
        rdata_frc = -1;

        ctl(8'h20); ctl(8'h81);
        f_frc = 1; idle(); f_frc = 0;
        check("irq_set", irq, 1);
        srd();
        check("irq_clr", irq, 0);
        f_frc = 1; srd(); f_frc = 0;
        check("irq_setwins", irq, 1);
        srd();
        check("irq_clr2", irq, 0);

        s_frc = 1; s_num_frc = 3; idle();
        s_num_frc = 9; idle(); s_frc = 0;
        srd();
        s_frc = 1; s_num_frc = 17; idle(); s_frc = 0;
        srd();

        ack_dly = 6;
        dwr(8'h11); dwr(8'h22);
        check("overrun_pulse", overrun, 1);
        wait_free();
        drd();
        check("overrun_one_inc", vram_addr, 17'h08002);
        wait_free();

        ack_dly = 8;
        drd(); idle();
        step(0, 0, 0, 0, 8'h00);
        check("reset_drops_req", vram_req, 0);
        idle();
        stray_ack = 1; rdata_frc = 8'h5A; idle();
        stray_ack = 0; rdata_frc = -1; ack_dly = -1;
        drd();
        check("post_reset_addr", vram_addr, 17'h00000);
        wait_free();

        ev_en = 1;
        for (int n = 0; n < 2500; n++) begin
            op = $urandom_range(0, 199);
            if (op < 2) step(0, 0, 0, 0, 8'h00);
            else if (op < 50) idle();
            else if (op < 80) dwr(8'($urandom_range(0, 255)));
            else if (op < 110) drd();
            else if (op < 160) ctl(8'($urandom_range(0, 255)));
            else if (op < 185) srd();
            else step(1, 1, 1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        ev_en = 0;
        repeat (4) idle();
        repeat (3) @(negedge pxclk);
        check("drain_state", st_q.size(), 0);
        check("drain_dout", dout_q.size(), 0);
        check("drain_req", req_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vdp_cpu_port.md
Name: vdp_cpu_port

Overview:
- Parametrised successor to the fixed TMS9918-style CPU front end of the vdp99 family.
- Owns the control-port two-byte latch, NUM_REGS control registers, and an auto-incrementing VRAM address counter up to 17 bits.
- Provides a one-byte read-ahead buffer and a status register with frame, 5th-sprite and collision flags plus IRQ.
- Talks to the VRAM arbiter over a req/ack handshake instead of driving RAM directly, so CPU accesses are serialised against display DMA.

Parameters:
- NUM_REGS, 8, number of 8-bit control registers; power of 2, 8..64.
- VRAM_AW, 14, VRAM address width; 14..17.
- BANK_REG, 14, register whose low (VRAM_AW-14) bits load the address MSBs. Used only when VRAM_AW>14 and BANK_REG<NUM_REGS.
- IE_REG, 1, register holding the interrupt-enable bit.
- IE_BIT, 5, bit position of the interrupt enable inside IE_REG.

Ports:
- pxclk  input  1  pixel clock; the only clock.
- reset_n  input  1  reset, synchronous, active-low.
- wr_tick  input  1  one-cycle CPU write strobe, pxclk domain.
- rd_tick  input  1  one-cycle CPU read strobe, pxclk domain.
- mode  input  1  0=data port, 1=control port; valid with a tick.
- din  input  8  CPU write data.
- dout  output  8  CPU read data; valid during rd_tick, 0 otherwise.
- regs  output  NUM_REGS*8  flattened register file; reg n occupies bits [8n+7:8n].
- frame_tick  input  1  end-of-frame pulse from vgasync.
- spr5_tick  input  1  fifth-sprite-on-line pulse from the display FSM.
- spr5_num  input  5  sprite number accompanying spr5_tick.
- coll_tick  input  1  sprite collision pulse.
- irq  output  1  interrupt request, registered.
- vram_req  output  1  VRAM access request.
- vram_we  output  1  1=write, 0=read; stable while vram_req is high.
- vram_addr  output  VRAM_AW  access address.
- vram_wdata  output  8  write data.
- vram_ack  input  1  one-cycle grant/completion pulse.
- vram_rdata  input  8  read data, valid with vram_ack.
- overrun  output  1  one-cycle pulse when a data-port op is dropped.

Behaviour:
- Reset (reset_n=0 at a pxclk edge):
  - Cleared to 0: regs, address counter, latch flag, read buffer, status, vram_req, irq, overrun, dout.
  - A reset while a request is pending drops vram_req next edge; any later ack is ignored.
- Control write, first byte (latch flag=0): store din in the temp latch; flag<=1.
- Control write, second byte (flag=1): flag<=0; decode din[7:6]:
  - 1x: write the temp latch to register din[5:0] mod NUM_REGS. If that register is BANK_REG, also load the address MSBs.
  - 00: addr <= {MSBs, din[5:0], temp}, then issue a read-ahead.
  - 01: addr <= {MSBs, din[5:0], temp}, no VRAM access.
- Data write: flag<=0; read buffer<=din; issue a write of din to addr; addr<=addr+1.
- Data read: dout=read buffer combinationally during rd_tick; flag<=0; issue a read-ahead of addr; addr<=addr+1.
- Address increment wraps modulo 2^VRAM_AW. The carry from bit 13 propagates into the MSBs; the BANK_REG value is not rewritten.
- Status byte is {F, 5S, C, fifth[4:0]}.
- Status read (mode=1 rd_tick):
  - dout shows the pre-clear status.
  - Next edge: F, 5S and C clear and the latch flag clears; irq falls on the same edge.
  - A set event in that same cycle wins: the bit stays 1.
- F is set by frame_tick.
- C is set by coll_tick.
- 5S is set by spr5_tick only while 5S=0. fifth<=spr5_num whenever 5S=0 and spr5_tick is high; it is frozen while 5S=1.
- irq<=F & regs[IE_REG][IE_BIT], registered; updates the edge after any change.
- VRAM FSM states: IDLE, RD_REQ, WR_REQ.
  - IDLE→RD_REQ/WR_REQ on the edge after a qualifying tick; vram_req=1 with addr/we/wdata frozen.
  - RD_REQ: on vram_ack, read buffer<=vram_rdata, →IDLE; vram_req=0 in the next cycle.
  - WR_REQ: on vram_ack, →IDLE.
  - Minimum latency is tick→req 1 cycle, ack possible in the same cycle as req.
- Data-port tick while not IDLE: the op is dropped. overrun pulses 1 cycle; no address increment, no buffer change, flag still clears. Register writes are unaffected by busy.
- Control-port ticks never touch VRAM except the 00 read-ahead. That read-ahead is also dropped with overrun if the FSM is busy.
- wr_tick and rd_tick in the same cycle: wr_tick is serviced, rd_tick is ignored.

Decomposition:
- Package vdp_pkg holds:
  - FSM state encodings.
  - Control command codes CMD_RD=2'b00, CMD_WR=2'b01, CMD_REG=2'b1x.
  - Status bit positions ST_F=7, ST_5S=6, ST_C=5.
- One sub-module, vdp_status_reg: flag set/clear priority, the fifth-sprite freeze, and irq generation.

Test Plan:
- Control writes 0x07 then 0x87 (NUM_REGS=8) → regs[7]=0x07 after the second tick; no vram_req.
- Control writes 0x00 then 0x40, then data writes 0xAA, 0x55 → vram_req writes: addr 0x0000 data 0xAA, then 0x0001 data 0x55 (ack 3 cycles later); counter ends at 0x0002.
- Control writes 0xFF then 0x3F, ack with rdata 0x12 → one read at 0x3FFF. The following data read returns dout=0x12 and issues a read at 0x0000 (VRAM_AW=14 wrap). With VRAM_AW=17 and regs[14]=1, the same sequence reads 0x7FFF then 0x8000.
- regs[1]=0x20, then frame_tick → irq=1 the next edge. Status read returns 0x80 and irq=0 one edge later. A frame_tick in the same cycle as the status read leaves F=1 and irq=1.
- spr5_tick with num 3, then with num 9 → status shows 0x43 (5S=1, fifth=3); after a status read, fifth follows the next spr5_num.
- Second data write while vram_ack is withheld → overrun pulses, counter +1 only once. Asserting reset_n=0 mid-request drops vram_req next edge, and a later ack leaves the buffer unchanged.
